// File: rtl/sub_bytes_iter.sv
// sub_bytes_iter: iterative AES SubBytes, BYTES_PER_CYCLE shared S-boxes, valid/ready on both sides
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] s
);
  localparam logic [0:2047] TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  assign s = TBL[8*int'(a) +: 8];
endmodule

module sub_bytes_iter #(
  parameter int BYTES_PER_CYCLE = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);
  localparam int N = 16 / BYTES_PER_CYCLE;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  localparam int CHUNK_W = 8 * BYTES_PER_CYCLE;
  if (BYTES_PER_CYCLE != 1 && BYTES_PER_CYCLE != 2 && BYTES_PER_CYCLE != 4 &&
      BYTES_PER_CYCLE != 8 && BYTES_PER_CYCLE != 16) begin : g_bad_param
    $error("sub_bytes_iter: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state_q, state_d;
  logic [127:0] data_q;
  logic [CW-1:0] cnt_q;
  logic [CHUNK_W-1:0] chunk_in, chunk_out;
  logic accept, last;
  assign in_ready = (state_q == IDLE) || (state_q == DONE && out_ready);
  assign out_valid = state_q == DONE;
  assign out_data = data_q;
  assign accept = in_valid && in_ready;
  assign last = cnt_q == CW'(N - 1);
  // chunk 0 is the most significant slice of the state
  assign chunk_in = data_q[127 - CHUNK_W*int'(cnt_q) -: CHUNK_W];
  for (genvar i = 0; i < BYTES_PER_CYCLE; i++) begin : g_sbox
    aes_sbox u_sbox (.a(chunk_in[CHUNK_W-1-8*i -: 8]), .s(chunk_out[CHUNK_W-1-8*i -: 8]));
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = accept ? BUSY : IDLE;
      BUSY:    state_d = last ? DONE : BUSY;
      DONE:    state_d = out_ready ? (in_valid ? BUSY : IDLE) : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      data_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        data_q <= in_data;
        cnt_q <= '0;
      end else if (state_q == BUSY) begin
        data_q[127 - CHUNK_W*int'(cnt_q) -: CHUNK_W] <= chunk_out;
        cnt_q <= last ? '0 : cnt_q + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_sub_bytes_iter.sv
// tb_sub_bytes_iter: directed vectors and handshake corner cases for sub_bytes_iter
module tb_sub_bytes_iter;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 1;
  logic [127:0] in_data = '0, sw_data = '0;
  logic in_ready, out_valid;
  logic [127:0] out_data;
  logic [3:0] sw_valid = '0, sw_in_ready, sw_out_valid;
  logic [127:0] sw_out [4];
  int checks = 0, errors = 0;
  typedef struct {logic [127:0] din; logic [127:0] dout;} vec_t;
  vec_t vecs [5];
  logic [127:0] blk [3], bexp [3];
  int sw_lat [4];
  int lat, idx, oc, last_c;
  logic acc;
  logic [127:0] fips_in, fips_out;

  always #5 clk = ~clk;

  sub_bytes_iter #(.BYTES_PER_CYCLE(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  for (genvar g = 0; g < 4; g++) begin : g_sw
    sub_bytes_iter #(.BYTES_PER_CYCLE(g == 0 ? 1 : g == 1 ? 2 : g == 2 ? 8 : 16)) u_sw (
      .clk(clk), .rst_n(rst_n), .in_valid(sw_valid[g]), .in_ready(sw_in_ready[g]), .in_data(sw_data),
      .out_valid(sw_out_valid[g]), .out_ready(1'b1), .out_data(sw_out[g])
    );
  end

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  task automatic wait_main(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 40);
    chk("out_valid_seen", 128'(out_valid), 128'(1));
  endtask

  task automatic run_one(input logic [127:0] din, input logic [127:0] dout, input string name);
    in_data = din;
    in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    in_data = ~din;
    chk({name, "_busy_in_ready"}, 128'(in_ready), 128'(0));
    wait_main(lat);
    chk({name, "_latency"}, 128'(lat), 128'(4));
    chk({name, "_data"}, out_data, dout);
    @(negedge clk);
    chk({name, "_valid_one_cycle"}, 128'(out_valid), 128'(0));
    chk({name, "_idle_in_ready"}, 128'(in_ready), 128'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    fips_in  = 128'h193de3be_a0f4e22b_9ac68d2a_e9f84808;
    fips_out = 128'hd42711ae_e0bf98f1_b8b45de5_1e415230;
    vecs[0] = '{128'h0, {16{8'h63}}};
    vecs[1] = '{fips_in, fips_out};
    vecs[2] = '{{16{8'hff}}, {16{8'h16}}};
    vecs[3] = '{{16{8'h53}}, {16{8'hed}}};
    vecs[4] = '{128'h00112233_44556677_8899aabb_ccddeeff, 128'h638293c3_1bfc33f5_c4eeacea_4bc12816};
    sw_lat = '{16, 8, 2, 1};
    repeat (2) @(negedge clk);
    rst_n = 1;
    chk("reset_out_valid", 128'(out_valid), 128'(0));
    chk("reset_in_ready", 128'(in_ready), 128'(1));
    chk("reset_out_data", out_data, 128'h0);

    for (int i = 0; i < 5; i++) run_one(vecs[i].din, vecs[i].dout, $sformatf("vec%0d", i));

    // reset in the middle of a block, then restart cleanly
    in_data = vecs[4].din;
    in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    repeat (2) @(negedge clk);
    rst_n = 0;
    #1;
    chk("midrst_out_valid", 128'(out_valid), 128'(0));
    chk("midrst_in_ready", 128'(in_ready), 128'(1));
    chk("midrst_out_data", out_data, 128'h0);
    @(negedge clk);
    rst_n = 1;
    run_one(fips_in, fips_out, "after_rst");

    // backpressure with a pending input block
    out_ready = 0;
    in_data = vecs[0].din;
    in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    wait_main(lat);
    chk("bp_latency", 128'(lat), 128'(4));
    in_data = vecs[3].din;
    in_valid = 1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_valid", 128'(out_valid), 128'(1));
      chk("bp_hold_data", out_data, vecs[0].dout);
      chk("bp_hold_in_ready", 128'(in_ready), 128'(0));
      @(negedge clk);
    end
    out_ready = 1;
    #1;
    chk("bp_release_in_ready", 128'(in_ready), 128'(1));
    @(negedge clk);
    in_valid = 0;
    chk("bp_transfer_done", 128'(out_valid), 128'(0));
    wait_main(lat);
    chk("bp_next_latency", 128'(lat), 128'(4));
    chk("bp_next_data", out_data, vecs[3].dout);
    @(negedge clk);

    // back-to-back stream, valid and ready tied high
    blk = '{vecs[0].din, vecs[2].din, vecs[3].din};
    bexp = '{vecs[0].dout, vecs[2].dout, vecs[3].dout};
    idx = 0;
    oc = 0;
    last_c = -1;
    in_data = blk[0];
    in_valid = 1;
    for (int c = 0; c < 40 && oc < 3; c++) begin
      acc = in_valid && in_ready;
      if (out_valid) begin
        chk($sformatf("stream_data%0d", oc), out_data, bexp[oc]);
        if (oc > 0) chk("stream_period", 128'(c - last_c), 128'(5));
        last_c = c;
        oc++;
      end
      @(negedge clk);
      if (acc) begin
        idx++;
        if (idx < 3) in_data = blk[idx];
        else in_valid = 0;
      end
    end
    in_valid = 0;
    chk("stream_count", 128'(oc), 128'(3));

    // other chunk widths
    for (int j = 0; j < 4; j++) begin
      sw_data = fips_in;
      sw_valid[j] = 1;
      @(negedge clk);
      sw_valid[j] = 0;
      sw_data = '0;
      chk($sformatf("sweep%0d_busy_in_ready", j), 128'(sw_in_ready[j]), 128'(0));
      lat = 0;
      do begin
        @(negedge clk);
        lat++;
      end while (!sw_out_valid[j] && lat < 40);
      chk($sformatf("sweep%0d_latency", j), 128'(lat), 128'(sw_lat[j]));
      chk($sformatf("sweep%0d_data", j), sw_out[j], fips_out);
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
